// File: rtl/instr_to_imm_if.sv
// Request/response bundle for the RV64 immediate generator.
// master: decode controller side; slave: immediate generator side.
interface instr_to_imm_if #(
  parameter int XLEN = 64
);
  // Request: raw instruction, format select, request strobe
  logic [31:0]     instr_i;
  logic [2:0]      ext_op;
  logic            in_valid;
  // Response: registered immediate, update strobe, reserved-format flag
  logic [XLEN-1:0] imm;
  logic            out_valid;
  logic            err;

  modport master (
    output instr_i,
    output ext_op,
    output in_valid,
    input  imm,
    input  out_valid,
    input  err
  );

  modport slave (
    input  instr_i,
    input  ext_op,
    input  in_valid,
    output imm,
    output out_valid,
    output err
  );
endinterface

// File: rtl/instr_to_imm.sv
// RV64 immediate generator: builds the I/U/S/B/J/shamt/zimm immediate
// selected by ext_op and registers it one cycle after a valid request.
// Ports: clk, rst_n (sync, active-low), bus (slave: instr_i, ext_op,
//   in_valid in; imm, out_valid, err out).
module instr_to_imm #(
  parameter int XLEN = 64
) (
  input logic           clk,
  input logic           rst_n,
  instr_to_imm_if.slave bus
);

  typedef enum logic [2:0] {
    EXT_I     = 3'd0,
    EXT_U     = 3'd1,
    EXT_S     = 3'd2,
    EXT_B     = 3'd3,
    EXT_J     = 3'd4,
    EXT_SHAMT = 3'd5,
    EXT_ZIMM  = 3'd6,
    EXT_RSVD  = 3'd7
  } ext_e;

  logic [31:0]     ins;
  logic            sgn;
  ext_e            op;

  logic [XLEN-1:0] imm_i_w;
  logic [XLEN-1:0] imm_u_w;
  logic [XLEN-1:0] imm_s_w;
  logic [XLEN-1:0] imm_b_w;
  logic [XLEN-1:0] imm_j_w;
  logic [XLEN-1:0] imm_sh_w;
  logic [XLEN-1:0] imm_z_w;

  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] imm_q;
  logic            err_d;
  logic            err_q;
  logic            vld_q;

  assign ins = bus.instr_i;
  assign sgn = ins[31];
  assign op  = ext_e'(bus.ext_op);

  // Signed formats replicate instr[31] into every upper bit
  assign imm_i_w = {{(XLEN-12){sgn}}, ins[31:20]};

  assign imm_u_w = {{(XLEN-32){sgn}}, ins[31:12], 12'b0};

  assign imm_s_w = {{(XLEN-12){sgn}},
                    ins[31:25], ins[11:7]};

  assign imm_b_w = {{(XLEN-13){sgn}}, ins[31],
                    ins[7], ins[30:25],
                    ins[11:8], 1'b0};

  assign imm_j_w = {{(XLEN-21){sgn}}, ins[31],
                    ins[19:12], ins[20],
                    ins[30:21], 1'b0};

  // 6-bit RV64 shift amount and CSR zimm are unsigned
  assign imm_sh_w = {{(XLEN-6){1'b0}}, ins[25:20]};

  assign imm_z_w = {{(XLEN-5){1'b0}}, ins[19:15]};

  always_comb begin
    imm_d = '0;
    err_d = 1'b0;
    case (op)
      EXT_I:     imm_d = imm_i_w;
      EXT_U:     imm_d = imm_u_w;
      EXT_S:     imm_d = imm_s_w;
      EXT_B:     imm_d = imm_b_w;
      EXT_J:     imm_d = imm_j_w;
      EXT_SHAMT: imm_d = imm_sh_w;
      EXT_ZIMM:  imm_d = imm_z_w;
      EXT_RSVD: begin
        imm_d = '0;
        err_d = 1'b1;
      end
      default: begin
        imm_d = '0;
        err_d = 1'b1;
      end
    endcase
  end

  // imm/err hold across idle cycles; out_valid pulses per request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imm_q <= '0;
      err_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        imm_q <= imm_d;
        err_q <= err_d;
      end
    end
  end

  assign bus.imm       = imm_q;
  assign bus.err       = err_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_instr_to_imm.sv
// Directed vector bench for instr_to_imm.
// Table of hand-computed immediates plus reset/hold sequences.
module tb_instr_to_imm;

  logic clk;
  logic rst_n;

  instr_to_imm_if #(.XLEN(64)) bus ();

  instr_to_imm #(.XLEN(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  op;
    logic [63:0] imm;
    logic        err;
  } vec_t;

  vec_t vecs [18];

  int n_cmp;
  int n_bad;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] ins,
                     input logic [2:0] op);
    bus.instr_i  = ins;
    bus.ext_op   = op;
    bus.in_valid = 1'b1;
  endtask

  task automatic chk_out(input string name,
                         input logic [63:0] imm,
                         input logic vld,
                         input logic err);
    chk({name, ".imm"}, bus.imm, imm);
    chk({name, ".out_valid"}, 64'(bus.out_valid), 64'(vld));
    chk({name, ".err"}, 64'(bus.err), 64'(err));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    vecs[0]  = '{32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{32'h7FF00093, 3'd0, 64'h00000000000007FF, 1'b0};
    vecs[2]  = '{32'h800000B7, 3'd1, 64'hFFFFFFFF80000000, 1'b0};
    vecs[3]  = '{32'h12345037, 3'd1, 64'h0000000012345000, 1'b0};
    vecs[4]  = '{32'hFE20BC23, 3'd2, 64'hFFFFFFFFFFFFFFF8, 1'b0};
    vecs[5]  = '{32'h0020A223, 3'd2, 64'h0000000000000004, 1'b0};
    vecs[6]  = '{32'hFE000EE3, 3'd3, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[7]  = '{32'h00000463, 3'd3, 64'h0000000000000008, 1'b0};
    vecs[8]  = '{32'hFFFFFFFF, 3'd3, 64'hFFFFFFFFFFFFFFFE, 1'b0};
    vecs[9]  = '{32'h0010006F, 3'd4, 64'h0000000000000800, 1'b0};
    vecs[10] = '{32'hFFDFF06F, 3'd4, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[11] = '{32'hFFFFFFFF, 3'd4, 64'hFFFFFFFFFFFFFFFE, 1'b0};
    vecs[12] = '{32'h03F09093, 3'd5, 64'h000000000000003F, 1'b0};
    vecs[13] = '{32'hFFFFFFFF, 3'd5, 64'h000000000000003F, 1'b0};
    vecs[14] = '{32'h000F8000, 3'd6, 64'h000000000000001F, 1'b0};
    vecs[15] = '{32'hFFFFFFFF, 3'd6, 64'h000000000000001F, 1'b0};
    vecs[16] = '{32'h00000013, 3'd0, 64'h0000000000000000, 1'b0};
    vecs[17] = '{32'hFFFFFFFF, 3'd7, 64'h0000000000000000, 1'b1};

    // Reset with valid traffic present: reset must win
    rst_n = 1'b0;
    req($urandom, 3'($urandom_range(0, 6)));
    step();
    chk_out("rst0", 64'h0, 1'b0, 1'b0);
    req($urandom, 3'($urandom_range(0, 6)));
    step();
    chk_out("rst1", 64'h0, 1'b0, 1'b0);

    // First request after release appears one edge later
    rst_n = 1'b1;
    req(32'hFFF00093, 3'd0);
    step();
    chk_out("first", 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0);

    foreach (vecs[i]) begin
      req(vecs[i].instr, vecs[i].op);
      step();
      chk_out($sformatf("vec%0d", i),
              vecs[i].imm, 1'b1, vecs[i].err);
    end

    // Reserved format then idle: imm=0, err=1 held
    req(32'h12345678, 3'd7);
    step();
    chk_out("rsvd", 64'h0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b0;
      bus.instr_i  = $urandom;
      bus.ext_op   = 3'(k);
      step();
      chk_out($sformatf("rsvd_hold%0d", k), 64'h0, 1'b0, 1'b1);
    end

    // Next valid I-type clears err
    req(32'hFFF00093, 3'd0);
    step();
    chk_out("clr_err", 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0);

    // Nonzero immediate held across idle cycles
    req(32'h12345037, 3'd1);
    step();
    chk_out("u_load", 64'h0000000012345000, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b0;
      bus.instr_i  = 32'hFFFFFFFF;
      bus.ext_op   = 3'd7;
      step();
      chk_out($sformatf("u_hold%0d", k),
              64'h0000000012345000, 1'b0, 1'b0);
    end

    // Reset mid-stream, then a reserved op so err is set beforehand
    req(32'h0010006F, 3'd4);
    step();
    chk_out("ms_a", 64'h0000000000000800, 1'b1, 1'b0);
    req(32'h0, 3'd7);
    step();
    chk_out("ms_b", 64'h0, 1'b1, 1'b1);
    req(32'hFE20BC23, 3'd2);
    step();
    chk_out("ms_c", 64'hFFFFFFFFFFFFFFF8, 1'b1, 1'b0);
    req(32'hFFFFFFFF, 3'd7);
    rst_n = 1'b0;
    step();
    chk_out("ms_rst", 64'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    req(32'h03F09093, 3'd5);
    step();
    chk_out("ms_after", 64'h000000000000003F, 1'b1, 1'b0);
    req(32'hFE000EE3, 3'd3);
    step();
    chk_out("ms_b2b", 64'hFFFFFFFFFFFFFFFC, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    step();
    chk_out("ms_idle", 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
